// File: rtl/gp_pkg.sv
// Shared definitions for the general-purpose register file.
// Memory-instruction encodings seen on the decode side.
package gp_pkg;

    typedef enum logic [1:0] {
        MI_NOP   = 2'b00,
        MI_LOAD  = 2'b01,
        MI_STORE = 2'b10,
        MI_WRITE = 2'b11
    } mem_instr_e;

endpackage

// File: rtl/gp_scoreboard.sv
// Load scoreboard: per-register busy bits, outstanding count,
// issue acceptance and sticky protocol-error detection.
module gp_scoreboard
    import gp_pkg::*;
#(
    parameter int NREGS   = 8,
    parameter int ZERO_R0 = 0,
    parameter int MAX_OUT = 4,
    localparam int ADDR_W = $clog2(NREGS),
    localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] sel_z_i,
    input  logic [1:0]        mem_instr_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_tag_i,
    output logic              ld_ready_o,
    output logic              ret_ok_o,
    output logic [NREGS-1:0]  busy_d_o,
    output logic [CNT_W-1:0]  out_cnt_o,
    output logic              err_o
);

    mem_instr_e       mi;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             z_zero;
    logic             issue;
    logic             ret_bad;
    logic             wr;

    assign mi      = mem_instr_e'(mem_instr_i);
    assign z_zero  = (ZERO_R0 != 0) && (sel_z_i == '0);
    assign wr      = (mi == MI_WRITE);
    assign ret_ok_o = ld_valid_i && busy_q[ld_tag_i];
    assign ret_bad = ld_valid_i && !busy_q[ld_tag_i];

    // Acceptance uses pre-edge busy, so a same-reg re-issue waits a cycle.
    assign ld_ready_o = z_zero ||
                        (!busy_q[sel_z_i] && (cnt_q < CNT_W'(MAX_OUT)));
    assign issue = (mi == MI_LOAD) && ld_ready_o && !z_zero;

    // Next busy/count/error: return clears before issue re-sets.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (ret_ok_o) begin
            busy_d[ld_tag_i] = 1'b0;
        end
        if (issue) begin
            busy_d[sel_z_i] = 1'b1;
        end
        unique case ({issue, ret_ok_o})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (ret_bad ||
            (wr && busy_q[sel_z_i]) ||
            (wr && ld_valid_i && (ld_tag_i == sel_z_i))) begin
            err_d = 1'b1;
        end
    end

    // Scoreboard state; reset drops any load in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_d_o  = busy_d;
    assign out_cnt_o = cnt_q;
    assign err_o     = err_q;

endmodule

// File: rtl/gp_reg_file.sv
// General-purpose register file: two registered read ports, a direct
// write port and a scoreboarded load-return write port with bypass.
module gp_reg_file
    import gp_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 8,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1,
    parameter int MAX_OUT = 4,
    localparam int ADDR_W = $clog2(NREGS),
    localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] sel_x,
    input  logic [ADDR_W-1:0] sel_y,
    input  logic [ADDR_W-1:0] sel_z,
    input  logic [1:0]        mem_instr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              ld_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_tag,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              hazard,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              err
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              hazard_q, hazard_d;
    logic [NREGS-1:0]  busy_d;
    logic              ret_ok;
    logic              wr_ok;

    gp_scoreboard #(
        .NREGS   (NREGS),
        .ZERO_R0 (ZERO_R0),
        .MAX_OUT (MAX_OUT)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_z_i     (sel_z),
        .mem_instr_i (mem_instr),
        .ld_valid_i  (ld_valid),
        .ld_tag_i    (ld_tag),
        .ld_ready_o  (ld_ready),
        .ret_ok_o    (ret_ok),
        .busy_d_o    (busy_d),
        .out_cnt_o   (out_cnt),
        .err_o       (err)
    );

    assign wr_ok = (mem_instr_e'(mem_instr) == MI_WRITE) &&
                   !((ZERO_R0 != 0) && (sel_z == '0));

    // Next storage: load return applied last so it wins a collision.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[sel_z] = mem_data;
        end
        if (ret_ok) begin
            regs_d[ld_tag] = ld_data;
        end
    end

    // Read mux: forwarded next value or current contents.
    always_comb begin
        a_d      = (BYPASS != 0) ? regs_d[sel_x] : regs_q[sel_x];
        b_d      = (BYPASS != 0) ? regs_d[sel_y] : regs_q[sel_y];
        hazard_d = busy_d[sel_x] | busy_d[sel_y];
    end

    // Storage and read-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q   <= '{default: '0};
            a_q      <= '0;
            b_q      <= '0;
            hazard_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hazard_q <= hazard_d;
        end
    end

    assign a      = a_q;
    assign b      = b_q;
    assign hazard = hazard_q;

endmodule
